// File: rtl/inst_cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped instruction cache.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package inst_cache_pkg;

   localparam int ADDR_W         = 32;
   localparam int DATA_W         = 32;
   localparam int LINES          = 16;
   localparam int WORDS_PER_LINE = 4;
   localparam int TAG_W          = 24;
   localparam int INDEX_W        = 4;
   localparam int OFFSET_W       = 2;

   // Refill FSM encoding; kept as plain constants so older fetch code can reuse it.
   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_REFILL    = 2'd1;
   localparam logic [1:0] ST_FILL_DONE = 2'd2;

   // Block-aligned byte address of a line: {tag, index, zero word/byte offset}.
   function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0]   tag,
                                                    input logic [INDEX_W-1:0] index);
      return {tag, index, {(ADDR_W-TAG_W-INDEX_W){1'b0}}};
   endfunction

endpackage

// File: rtl/inst_cache_ram.sv
// Data (16 lines x 4 words) and tag storage for the instruction cache.
// Latency: combinational read, write takes effect on the next rising edge.
// Backpressure: none; a single write port driven only by the refill path.
module icache_ram
   import inst_cache_pkg::*;
(
   input  logic                Clk,
   input  logic                wr_en_i,
   input  logic [INDEX_W-1:0]  wr_index_i,
   input  logic [OFFSET_W-1:0] wr_offset_i,
   input  logic [DATA_W-1:0]   wr_data_i,
   input  logic                tag_wr_i,
   input  logic [TAG_W-1:0]    wr_tag_i,
   input  logic [INDEX_W-1:0]  rd_index_i,
   input  logic [OFFSET_W-1:0] rd_offset_i,
   output logic [DATA_W-1:0]   rd_data_o,
   output logic [TAG_W-1:0]    rd_tag_o
);

   logic [DATA_W-1:0] data_q [LINES][WORDS_PER_LINE];
   logic [TAG_W-1:0]  tag_q  [LINES];

   // Refill writes: one data word per beat, tag alongside the final word of the line.
   always_ff @(posedge Clk) begin
      if (wr_en_i) begin
         data_q[wr_index_i][wr_offset_i] <= wr_data_i;
      end
      if (tag_wr_i) begin
         tag_q[wr_index_i] <= wr_tag_i;
      end
   end

   assign rd_data_o = data_q[rd_index_i][rd_offset_i];
   assign rd_tag_o  = tag_q[rd_index_i];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache, 16 lines x 4 words, 4-beat refill.
// Latency: hit is combinational; a miss costs 1 cycle + 4 memValid beats + 1 settle cycle.
// Backpressure: fetch holds its PC while hit=0; refill advances only on memValid beats.
module inst_cache
   import inst_cache_pkg::*;
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic [ADDR_W-1:0] pcIn,
   input  logic              flush,
   output logic [DATA_W-1:0] inst,
   output logic              hit,
   output logic              memReq,
   output logic [ADDR_W-1:0] memAddr,
   input  logic [DATA_W-1:0] memRdata,
   input  logic              memValid
);

   logic [1:0]          state_q, state_d;
   logic [OFFSET_W-1:0] beat_q, beat_d;
   logic [LINES-1:0]    valid_q, valid_d;
   logic [TAG_W-1:0]    miss_tag_q, miss_tag_d;
   logic [INDEX_W-1:0]  miss_idx_q, miss_idx_d;

   logic [TAG_W-1:0]    pc_tag;
   logic [INDEX_W-1:0]  pc_idx;
   logic [OFFSET_W-1:0] pc_off;
   logic [DATA_W-1:0]   rd_data;
   logic [TAG_W-1:0]    rd_tag;
   logic                line_match;
   logic                beat_wr;
   logic                unused_pc_bits;

   assign pc_tag = pcIn[ADDR_W-1 -: TAG_W];
   assign pc_idx = pcIn[ADDR_W-TAG_W-1 -: INDEX_W];
   assign pc_off = pcIn[ADDR_W-TAG_W-INDEX_W-1 -: OFFSET_W];
   // Byte offset within the word is meaningless for an aligned fetch.
   assign unused_pc_bits = ^pcIn[1:0];

   // A beat is accepted only while a refill is outstanding.
   assign beat_wr = (state_q == ST_REFILL) && memValid;

   icache_ram u_ram (
      .Clk         (Clk),
      .wr_en_i     (beat_wr),
      .wr_index_i  (miss_idx_q),
      .wr_offset_i (beat_q),
      .wr_data_i   (memRdata),
      .tag_wr_i    (beat_wr && (beat_q == OFFSET_W'(WORDS_PER_LINE-1))),
      .wr_tag_i    (miss_tag_q),
      .rd_index_i  (pc_idx),
      .rd_offset_i (pc_off),
      .rd_data_o   (rd_data),
      .rd_tag_o    (rd_tag)
   );

   // Raw array match, independent of FSM state and flush.
   assign line_match = valid_q[pc_idx] && (rd_tag == pc_tag);

   // Hits only in IDLE; a flush cycle reports a miss so fetch never consumes a line being invalidated.
   assign hit     = (state_q == ST_IDLE) && !flush && line_match;
   assign inst    = hit ? rd_data : '0;
   assign memReq  = (state_q == ST_REFILL);
   assign memAddr = block_addr(miss_tag_q, miss_idx_q);

   // Next-state: miss capture, beat counting, line validation and flush invalidation.
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      valid_d    = valid_q;
      miss_tag_d = miss_tag_q;
      miss_idx_d = miss_idx_q;
      case (state_q)
         ST_IDLE: begin
            if (flush) begin
               valid_d = '0;
            end else if (!line_match) begin
               state_d    = ST_REFILL;
               beat_d     = '0;
               miss_tag_d = pc_tag;
               miss_idx_d = pc_idx;
            end
         end
         ST_REFILL: begin
            // Flush drops resident lines but the in-flight line is still validated below.
            if (flush) begin
               valid_d = '0;
            end
            if (memValid) begin
               beat_d = beat_q + OFFSET_W'(1);
               if (beat_q == OFFSET_W'(WORDS_PER_LINE-1)) begin
                  valid_d[miss_idx_q] = 1'b1;
                  state_d             = ST_FILL_DONE;
               end
            end
         end
         ST_FILL_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State registers; reset abandons any refill and leaves every line invalid.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q    <= ST_IDLE;
         beat_q     <= '0;
         valid_q    <= '0;
         miss_tag_q <= '0;
         miss_idx_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         valid_q    <= valid_d;
         miss_tag_q <= miss_tag_d;
         miss_idx_q <= miss_idx_d;
      end
   end

endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
- REQ-001: The block SHALL expose the following ports (clock and reset first; one clock; reset asynchronous, active-high):
- REQ-002: Clk  input  1  rising-edge clock for all state.
- REQ-003: Rst  input  1  asynchronous, active-high reset.
- REQ-004: pcIn  input  32  fetch address from the fetch stage, word-aligned; bits [1:0] ignored.
- REQ-005: flush  input  1  invalidate all lines (synchronous, one-cycle pulse).
- REQ-006: inst  output  32  instruction word at pcIn when hit=1; 32'h00000000 (NOP) otherwise.
- REQ-007: hit  output  1  pcIn resident and valid; fetch advances the PC only when hit=1.
- REQ-008: memReq  output  1  refill request to backing memory, held high for the whole refill.
- REQ-009: memAddr  output  32  block-aligned refill address {tag,index,4'b0000}; stable while memReq=1.
- REQ-010: memRdata  input  32  refill data beat.
- REQ-011: memValid  input  1  memRdata valid this cycle; one word per beat, words in ascending order.

Function
- REQ-012: Geometry SHALL be direct-mapped, 16 lines of 4 words each: tag=pcIn[31:8], index=pcIn[7:4], word offset=pcIn[3:2].
- REQ-013: Lookup SHALL be combinational: hit = (state==IDLE) & valid[index] & (tag[index]==pcIn[31:8]); inst = data[index][offset] when hit, else 0.
- REQ-014: The FSM SHALL have three states: IDLE, REFILL, FILL_DONE.
- REQ-015: IDLE -> REFILL on the rising edge where a lookup misses and flush=0; latch the miss tag/index and drive memAddr from the latched values.
- REQ-016: In REFILL, memReq=1; each memValid writes memRdata to data[latched index][beat] and increments a 2-bit beat counter starting at 0.
- REQ-017: On the fourth memValid (beat counter = 3), write tag[index] and set valid[index] on the same edge; go to FILL_DONE. memReq SHALL be low in FILL_DONE.
- REQ-018: FILL_DONE -> IDLE unconditionally after one cycle; a missing PC therefore sees hit=1 no earlier than 1 cycle after the last beat.
- REQ-019: hit SHALL be 0 in REFILL and FILL_DONE regardless of array contents.
- REQ-020: If pcIn changes during REFILL, the refill SHALL complete for the latched block; the new pcIn is looked up in IDLE.
- REQ-021: memValid while in IDLE or FILL_DONE SHALL be ignored.
- REQ-022: flush in IDLE SHALL clear all 16 valid bits on that edge; hit is 0 in the flush cycle.
- REQ-023: flush during REFILL SHALL clear all valid bits immediately; the refill still completes and validates its line (flush wins only for lines already resident).
- REQ-024: A refill that replaces a valid line with a different tag SHALL overwrite it (no write-back; read-only cache).
- REQ-025: Address wrap: pcIn=32'hFFFFFFFC SHALL map to index 15, offset 3, with memAddr=32'hFFFFFFF0.

Reset
- REQ-026: Rst SHALL asynchronously force state=IDLE, beat counter=0, all valid bits=0, memReq=0, memAddr=0.
- REQ-027: After Rst, hit SHALL be 0 and inst SHALL be 0 for any pcIn.
- REQ-028: Rst mid-refill SHALL abandon the refill; the partially written line SHALL remain invalid.
- REQ-029: Data and tag arrays SHALL NOT require reset.

Structure
- REQ-030: A shared package SHALL hold the geometry constants (LINES=16, WORDS_PER_LINE=4, TAG_W=24, INDEX_W=4, OFFSET_W=2) and the FSM state encoding, for reuse by the fetch stage and benches.
- REQ-031: Storage SHALL be one sub-module, icache_ram (16x4x32 data plus 16x24 tag, one write port, combinational read); valid bits and the FSM stay in inst_cache.

Verification
- REQ-032: Cold miss: reset, pcIn=0x00000040, memory returns 0x11,0x22,0x33,0x44 over 4 cycles -> memReq=1 with memAddr=0x00000040; hit=1 and inst=0x11 one cycle after the fourth beat.
- REQ-033: Hit path: after REQ-032, pcIn=0x0000004C -> hit=1, inst=0x44 in the same cycle, memReq stays 0.
- REQ-034: Conflict eviction: pcIn=0x00000140 (same index 4, tag 1) -> refill with memAddr=0x00000140; afterwards pcIn=0x00000040 misses again.
- REQ-035: Flush: after a valid line, pulse flush=1 for one cycle -> next-cycle lookup of 0x00000040 misses and memReq rises.
- REQ-036: Reset mid-refill: assert Rst after beat 2 -> memReq=0 immediately; after release, pcIn=0x00000040 misses and a full 4-beat refill restarts.
- REQ-037: Gapped beats and PC change: memValid every other cycle while pcIn changes to 0x00000080 mid-refill -> the 0x40 line completes and validates, then 0x80 misses and refills.
